alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX issue register that drives the ALU inputs: Operand1, Operand2, ALUOperation and Shamt.
- Decodes a 32-bit MIPS instruction into the 5-bit ALU operation code and selects and extends the operands.
- Applies EX/MEM and MEM/WB forwarding at capture time.
- Holds one instruction under a valid/ready handshake, with stall and flush.

Parameters:
- RESET_OP, 5'b00001: ALU code driven on out_alu_op during reset and for bubbles (ADDU).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode stage offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_rs_data  in  32  register-file value of rs.
- in_rt_data  in  32  register-file value of rt.
- fwd1_en, fwd1_reg, fwd1_data  in  1/5/32  EX/MEM result forwarding.
- fwd2_en, fwd2_reg, fwd2_data  in  1/5/32  MEM/WB result forwarding.
- flush  in  1  squash the held entry and the incoming one.
- out_valid  out  1  issued entry present.
- out_ready  in  1  EX accepts the entry.
- out_op1  out  32  to ALU Operand1.
- out_op2  out  32  to ALU Operand2.
- out_alu_op  out  5  to ALU ALUOperation.
- out_shamt  out  5  to ALU Shamt.
- out_dest  out  5  destination register.
- out_reg_write  out  1  destination is written.
- out_illegal  out  1  instruction not decodable.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_op1=0, out_op2=0, out_alu_op=RESET_OP, out_shamt=0, out_dest=0, out_reg_write=0, out_illegal=0.
  - Reset asserted mid-stall drops the held entry immediately.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture on in_valid && in_ready; latency is 1 cycle to out_valid.
  - While out_valid && !out_ready, every out_* holds stable.
  - Accept with no new capture → out_valid=0 next cycle.
  - Simultaneous accept and capture → the new entry replaces the old one with no bubble.
- Flush:
  - Has priority over everything: next cycle out_valid=0, out_reg_write=0, out_illegal=0.
  - An incoming instruction in the same cycle is discarded.
- Forwarding (at capture only; no re-evaluation while held):
  - rs value = fwd1_data if fwd1_en && fwd1_reg==rs && rs!=0; else fwd2_data under the same test on fwd2; else in_rs_data.
  - rt value resolved the same way.
  - Register 0 is never forwarded.
- Decode, with op=instr[31:26], funct=instr[5:0], imm=instr[15:0]:
  - R-type (op=0): op1=rs value, op2=rt value, shamt=instr[10:6], dest=rd, reg_write=1.
  - R-type funct → code:
    - 20 → 00010, 21 → 00001, 22 → 00100, 23 → 00011
    - 24 → 01101, 25 → 01110, 26 → 01111, 27 → 10000
    - 00 → 10001, 02 → 10011, 03 → 10010
    - 04 → 10100, 06 → 10110, 07 → 10101
    - 2A → 10111, 2B → 11000
  - I-type: op1=rs value, dest=rt, reg_write=1, shamt=0.
  - I-type op → code, op2:
    - 08 → 00010, sign-extended imm
    - 09 → 00001, sign-extended imm
    - 0A → 10111, sign-extended imm
    - 0B → 11000, sign-extended imm
    - 0C → 01101, zero-extended imm
    - 0D → 01110, zero-extended imm
    - 0E → 01111, zero-extended imm
    - 0F → 00000, zero-extended imm (the ALU applies the <<16)
  - lw (23) / sw (2B): code 00001, op2 = sign-extended imm; reg_write=1 for lw, 0 for sw.
  - beq (04) / bne (05): code 00011, op2 = rt value, reg_write=0.
  - Any other op/funct: out_illegal=1, code=RESET_OP, reg_write=0, op1=op2=0.
  - dest=0 forces reg_write=0.
- Encodings 00101–01100 and 11001–11111 are never driven.

Test Plan:
- Reset, then `add $3,$1,$2` (0x00221820) with rs=5, rt=7, out_ready=1 → next cycle out_valid=1, alu_op=00010, op1=5, op2=7, dest=3, reg_write=1.
- `addiu $4,$0,0xFFFF` → op2=0xFFFFFFFF, alu_op=00001; `ori` with imm 0xFFFF → op2=0x0000FFFF, alu_op=01110.
- `sra $2,$3,4` with rt=0x80000000 → alu_op=10010, shamt=4, op2=0x80000000.
- fwd1 and fwd2 both match rs=1 (fwd1_data=0xA, fwd2_data=0xB) → op1=0xA; rs=0 with fwd1_reg=0 → op1=in_rs_data.
- out_ready=0 for 3 cycles with new in_valid → in_ready=0 and outputs stable; flush during the stall → out_valid=0 next cycle and the incoming instruction is dropped.
- Opcode 0x3F → out_illegal=1, alu_op=00001, reg_write=0; rst_n pulsed low while out_valid=1 → out_valid=0 immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes a MIPS instruction into ALU code/operands,
// resolves EX/MEM and MEM/WB forwarding at capture, and holds one entry.
module alu_issue_stage #(
  parameter logic [4:0] RESET_OP = 5'b00001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic        fwd1_en,
  input  logic [4:0]  fwd1_reg,
  input  logic [31:0] fwd1_data,
  input  logic        fwd2_en,
  input  logic [4:0]  fwd2_reg,
  input  logic [31:0] fwd2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [4:0]  out_alu_op,
  output logic [4:0]  out_shamt,
  output logic [4:0]  out_dest,
  output logic        out_reg_write,
  output logic        out_illegal
);

  // Handshake: an input transfer happens on in_valid && in_ready; an output
  // transfer on out_valid && out_ready. A held entry never changes.
  assign in_ready = !out_valid || out_ready;

  logic        capture;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_s, imm_z, rs_val, rt_val;

  assign capture = in_valid && in_ready && !flush;
  assign op      = in_instr[31:26];
  assign funct   = in_instr[5:0];
  assign rs      = in_instr[25:21];
  assign rt      = in_instr[20:16];
  assign rd      = in_instr[15:11];
  assign imm_s   = {{16{in_instr[15]}}, in_instr[15:0]};
  assign imm_z   = {16'h0000, in_instr[15:0]};

  // EX/MEM wins over MEM/WB; $0 is hard-wired and never forwarded.
  always_comb begin
    rs_val = in_rs_data;
    if (fwd1_en && fwd1_reg == rs && rs != 5'd0)      rs_val = fwd1_data;
    else if (fwd2_en && fwd2_reg == rs && rs != 5'd0) rs_val = fwd2_data;
    rt_val = in_rt_data;
    if (fwd1_en && fwd1_reg == rt && rt != 5'd0)      rt_val = fwd1_data;
    else if (fwd2_en && fwd2_reg == rt && rt != 5'd0) rt_val = fwd2_data;
  end

  logic [31:0] d_op1, d_op2;
  logic [4:0]  d_code, d_shamt, d_dest;
  logic        d_wr, d_ill;

  always_comb begin
    d_op1   = rs_val;
    d_op2   = imm_s;
    d_code  = RESET_OP;
    d_shamt = 5'd0;
    d_dest  = rt;
    d_wr    = 1'b1;
    d_ill   = 1'b0;
    case (op)
      6'h00: begin
        d_op2   = rt_val;
        d_shamt = in_instr[10:6];
        d_dest  = rd;
        case (funct)
          6'h20: d_code = 5'b00010;
          6'h21: d_code = 5'b00001;
          6'h22: d_code = 5'b00100;
          6'h23: d_code = 5'b00011;
          6'h24: d_code = 5'b01101;
          6'h25: d_code = 5'b01110;
          6'h26: d_code = 5'b01111;
          6'h27: d_code = 5'b10000;
          6'h00: d_code = 5'b10001;
          6'h02: d_code = 5'b10011;
          6'h03: d_code = 5'b10010;
          6'h04: d_code = 5'b10100;
          6'h06: d_code = 5'b10110;
          6'h07: d_code = 5'b10101;
          6'h2A: d_code = 5'b10111;
          6'h2B: d_code = 5'b11000;
          default: d_ill = 1'b1;
        endcase
      end
      6'h08: d_code = 5'b00010;
      6'h09: d_code = 5'b00001;
      6'h0A: d_code = 5'b10111;
      6'h0B: d_code = 5'b11000;
      6'h0C: begin d_code = 5'b01101; d_op2 = imm_z; end
      6'h0D: begin d_code = 5'b01110; d_op2 = imm_z; end
      6'h0E: begin d_code = 5'b01111; d_op2 = imm_z; end
      6'h0F: begin d_code = 5'b00000; d_op2 = imm_z; end
      6'h23: d_code = 5'b00001;
      6'h2B: begin d_code = 5'b00001; d_wr = 1'b0; d_dest = 5'd0; end
      6'h04, 6'h05: begin
        d_code = 5'b00011;
        d_op2  = rt_val;
        d_wr   = 1'b0;
        d_dest = 5'd0;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_op1   = 32'd0;
      d_op2   = 32'd0;
      d_code  = RESET_OP;
      d_shamt = 5'd0;
      d_dest  = 5'd0;
      d_wr    = 1'b0;
    end
    if (d_dest == 5'd0) d_wr = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_op1       <= 32'd0;
      out_op2       <= 32'd0;
      out_alu_op    <= RESET_OP;
      out_shamt     <= 5'd0;
      out_dest      <= 5'd0;
      out_reg_write <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      out_op1       <= d_op1;
      out_op2       <= d_op2;
      out_alu_op    <= d_code;
      out_shamt     <= d_shamt;
      out_dest      <= d_dest;
      out_reg_write <= d_wr;
      out_illegal   <= d_ill;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule
